stim_sequencer: RTL and testbench

Stimulus sequencer for the fuzz-harness `top` datapath. It holds the DUT in reset, then generates a deterministic stream of `IN_W`-bit input vectors from a 32-bit LCG. Each vector is offered to the DUT-side driver through a valid/ready handshake, and the block counts vectors until the programmed length is reached. It replaces free-running testbench stimulus loops with a synthesizable, cycle-exact controller, so every simulator sees identical input sequences.

---
 rtl/stim_sequencer.sv | 178 +++++++++++++++++
 tb/tb_stim_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stim_sequencer.sv
// stim_sequencer: synthesizable stimulus controller for the fuzz-harness datapath.
// It holds the DUT in reset for RST_CYCLES cycles. It then emits a deterministic stream of
// IN_W-bit vectors built from a 32-bit LCG, each offered through a valid/ready handshake.
// A run produces cycles+1 vectors.
// Optional feature: define STIM_SEQ_PARALLEL_FILL_EN to compute all words of a vector
// in a single FILL cycle. The default is a serial fill, one LCG step per cycle.
//
// Handshake: vec_valid rises only when in_flat holds a complete new vector. vec_valid and
// in_flat then stay stable until the consumer raises vec_ready. The transfer happens on the
// rising edge where vec_valid && vec_ready. vec_valid never drops without a transfer,
// except on rst.
module stim_sequencer #(
  parameter int IN_W       = 135,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             dut_rst_n,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [IN_W-1:0]  in_flat,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int NW   = (IN_W + 31) / 32;
  localparam int SH_W = NW * 32;
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_FILL    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // One LCG step, modulo 2^32.
  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    lcg_next = s * 32'h41C64E6D + 32'h3039;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       lcg_q, lcg_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]   in_flat_q, in_flat_d;
`ifdef STIM_SEQ_PARALLEL_FILL_EN
  logic [31:0]       chain;
`else
  localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
`endif

  // State and datapath registers; rst returns everything to the idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lcg_q     <= '0;
      cycles_q  <= '0;
      idx_q     <= '0;
      rcnt_q    <= '0;
      shadow_q  <= '0;
      in_flat_q <= '0;
`ifndef STIM_SEQ_PARALLEL_FILL_EN
      wcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lcg_q     <= lcg_d;
      cycles_q  <= cycles_d;
      idx_q     <= idx_d;
      rcnt_q    <= rcnt_d;
      shadow_q  <= shadow_d;
      in_flat_q <= in_flat_d;
`ifndef STIM_SEQ_PARALLEL_FILL_EN
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  // Next-state logic: reset hold, vector fill, presentation and run termination.
  always_comb begin
    state_d   = state_q;
    lcg_d     = lcg_q;
    cycles_d  = cycles_q;
    idx_d     = idx_q;
    rcnt_d    = rcnt_q;
    shadow_d  = shadow_q;
    in_flat_d = in_flat_q;
`ifdef STIM_SEQ_PARALLEL_FILL_EN
    chain     = lcg_q;
`else
    wcnt_d    = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RESET;
          lcg_d    = seed;
          cycles_d = cycles;
          idx_d    = '0;
          rcnt_d   = '0;
        end
      end
      S_RESET: begin
        if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_FILL;
`ifndef STIM_SEQ_PARALLEL_FILL_EN
          wcnt_d  = '0;
`endif
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      S_FILL: begin
`ifdef STIM_SEQ_PARALLEL_FILL_EN
        // All NW chained steps in one cycle; contents match the serial fill.
        for (int k = 0; k < NW; k++) begin
          chain = lcg_next(chain);
          shadow_d[k*32 +: 32] = chain;
        end
        lcg_d     = chain;
        in_flat_d = shadow_d[IN_W-1:0];
        state_d   = S_PRESENT;
`else
        // One step per cycle; word k lands at bits [32k+31:32k].
        lcg_d = lcg_next(lcg_q);
        shadow_d[{wcnt_q, 5'b00000} +: 32] = lcg_d;
        if (wcnt_q == WC_W'(NW - 1)) begin
          in_flat_d = shadow_d[IN_W-1:0];
          state_d   = S_PRESENT;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
`endif
      end
      S_PRESENT: begin
        // Compare before incrementing so cycles = all-ones terminates cleanly.
        if (vec_ready) begin
          if (idx_q == cycles_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_FILL;
`ifndef STIM_SEQ_PARALLEL_FILL_EN
            wcnt_d  = '0;
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded directly from the state register.
  assign busy      = (state_q != S_IDLE);
  assign dut_rst_n = (state_q == S_FILL) || (state_q == S_PRESENT) || (state_q == S_DONE);
  assign vec_valid = (state_q == S_PRESENT);
  assign done      = (state_q == S_DONE);
  assign in_flat   = in_flat_q;
  assign vec_idx   = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Testbench for stim_sequencer.
// A reference LCG model fills an expected-vector queue for each run. A per-cycle monitor
// checks latency, the inter-vector gap, vector contents, index, hold-under-backpressure,
// the done timing and asynchronous reset.
module tb_stim_sequencer;
  localparam int IN_W       = 135;
  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 32;
  localparam int NW         = (IN_W + 31) / 32;
`ifdef STIM_SEQ_PARALLEL_FILL_EN
  localparam int FIRST = 2 + RST_CYCLES;
  localparam int GAP   = 1;
`else
  localparam int FIRST = 1 + RST_CYCLES + NW;
  localparam int GAP   = NW;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] cycles;
  logic             dut_rst_n;
  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  in_flat;
  logic [CNT_W-1:0] vec_idx;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [IN_W-1:0] exp_q[$];

  stim_sequencer #(.IN_W(IN_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .cycles(cycles),
    .dut_rst_n(dut_rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .in_flat(in_flat), .vec_idx(vec_idx), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: NW successive LCG states packed low word first, truncated to IN_W.
  function automatic logic [IN_W-1:0] model_vec(inout logic [31:0] st);
    logic [NW*32-1:0] w;
    w = '0;
    for (int k = 0; k < NW; k++) begin
      st = st * 32'h41C64E6D + 32'h3039;
      w[k*32 +: 32] = st;
    end
    return w[IN_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dut_rst_n"}, 160'(dut_rst_n), 160'(0));
    chk({tag, "_vec_valid"}, 160'(vec_valid), 160'(0));
    chk({tag, "_in_flat"},   160'(in_flat),   160'(0));
    chk({tag, "_vec_idx"},   160'(vec_idx),   160'(0));
    chk({tag, "_busy"},      160'(busy),      160'(0));
    chk({tag, "_done"},      160'(done),      160'(0));
  endtask

  // One run: start, then monitor every cycle at the falling edge.
  // stall_pct: chance of vec_ready=0. hold0: forced low cycles on the first valid.
  // abort_k: cycle at which rst is pulsed (-1 for none). poke: pulse start while busy.
  task automatic run(input logic [31:0] s, input logic [31:0] c, input int stall_pct,
                     input int hold0, input int abort_k, input bit poke,
                     output logic [IN_W-1:0] v0);
    logic [31:0]     m;
    logic [IN_W-1:0] held;
    logic [IN_W-1:0] exp_v;
    int k, last_hs, n, hold_left;
    bit prev_valid, finished;
    m = s;
    exp_q.delete();
    for (int i = 0; i <= int'(c); i++) exp_q.push_back(model_vec(m));
    v0 = '0;
    held = '0;
    @(negedge clk);
    start = 1'b1; seed = s; cycles = c; vec_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1; last_hs = 0; n = 0; prev_valid = 1'b0; finished = 1'b0; hold_left = hold0;
    chk("busy_after_start", 160'(busy), 160'(1));
    while (!finished && k < 3000) begin
      if (k == RST_CYCLES)     chk("rst_n_low_last", 160'(dut_rst_n), 160'(0));
      if (k == RST_CYCLES + 1) chk("rst_n_rise", 160'(dut_rst_n), 160'(1));
      if (poke && k == 3) begin start = 1'b1; seed = ~s; cycles = c + 5; end
      if (poke && k == 4) begin start = 1'b0; seed = s; cycles = c; end
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        chk_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        vec_ready = 1'b0;
        finished = 1'b1;
      end else begin
        if (vec_valid && !prev_valid) begin
          chk("vec_latency", 160'(k), 160'((n == 0) ? FIRST : last_hs + 1 + GAP));
          chk("vec_idx", 160'(vec_idx), 160'(n));
          if (exp_q.size() == 0) begin
            chk("vec_count", 160'(n), 160'(c));
          end else begin
            exp_v = exp_q.pop_front();
            chk("in_flat", 160'(in_flat), 160'(exp_v));
          end
          if (n == 0) v0 = in_flat;
          held = in_flat;
        end else if (vec_valid) begin
          chk("hold_in_flat", 160'(in_flat), 160'(held));
          chk("hold_vec_idx", 160'(vec_idx), 160'(n));
        end
        if (done) begin
          chk("done_timing", 160'(k), 160'(last_hs + 1));
          chk("vec_total", 160'(n), 160'(c) + 160'(1));
          finished = 1'b1;
        end
        prev_valid = vec_valid;
        if (vec_valid && hold_left > 0) begin
          vec_ready = 1'b0;
          hold_left--;
        end else begin
          vec_ready = ($urandom_range(99) >= stall_pct);
        end
        if (vec_valid && vec_ready) begin
          last_hs = k;
          n++;
        end
      end
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end
    if (!finished) chk("timeout", 160'(k), 160'(0));
    vec_ready = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0] v, va, vb;
    logic [31:0]     sa;
    rst = 1'b1; start = 1'b0; seed = '0; cycles = '0; vec_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    // Seed 0, single vector, always ready.
    run(32'd0, 32'd0, 0, 0, -1, 1'b0, v);
    chk("seed0_word0", 160'(v[31:0]), 160'(32'h00003039));
    chk("seed0_word1", 160'(v[63:32]), 160'(32'hD3DC167E));
    @(negedge clk);
    chk("idle_busy", 160'(busy), 160'(0));
    chk("idle_rst_n", 160'(dut_rst_n), 160'(0));
    chk("idle_holds_in_flat", 160'(in_flat), 160'(v));

    // Seed 1, four vectors; immediately followed by a restart with a new seed.
    run(32'd1, 32'd3, 0, 0, -1, 1'b0, v);
    chk("seed1_word0", 160'(v[31:0]), 160'(32'h41C67EA6));
    run(32'hDEADBEEF, 32'd2, 0, 10, -1, 1'b1, v);

    // Asynchronous reset mid-FILL and mid-PRESENT, then reproduce vector 0.
    sa = $urandom;
    run(sa, 32'd3, 0, 0, RST_CYCLES + 1, 1'b0, v);
    run(sa, 32'd3, 0, 100, FIRST + 2, 1'b0, va);
    run(sa, 32'd1, 0, 0, -1, 1'b0, vb);
    chk("repro_vec0", 160'(vb), 160'(va));

    // Randomized runs with random backpressure.
    for (int r = 0; r < 6; r++) begin
      run($urandom, 32'($urandom_range(4)), $urandom_range(60), $urandom_range(3), -1, 1'b0, v);
    end
    @(negedge clk);
    chk("final_idle", 160'(busy), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
